seq_mult_ctrl: RTL

Multi-cycle unsigned 32x32 -> 64 shift-add multiplier. The block sequences the shared 32-bit ripple adder through 32 conditional add/shift iterations under a start/busy/done handshake. It serves the multi-cycle MULT path of the processor, where a single-cycle combinational multiplier is too large and too slow. The adder has no carry-out port, so the controller recovers the carry from the operand and sum MSBs.

---
 rtl/seq_mult_ctrl_pkg.sv | 19 +
 rtl/seq_mult_ctrl_if.sv | 31 +++
 rtl/seq_mult_ctrl_adder.sv | 16 +
 rtl/seq_mult_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seq_mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl_pkg
// Shared definitions for the multi-cycle shift-add multiplier:
//   WIDTH     - operand width, tied to the shared ripple adder
//   ITER_LAST - iteration count value at which the last add/shift happens
//   state_t   - controller state encoding
// -----------------------------------------------------------------------------
package seq_mult_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl_if
// Request/response bundle for the sequential multiplier.
//   start   - request, sampled by the controller in IDLE or DONE
//   a, b    - multiplicand / multiplier, captured on the accepting edge
//   busy    - high while the iteration loop runs
//   done    - one-cycle completion pulse
//   product - last completed result, held until the next completion
// master: the requester; slave: the multiplier.
// -----------------------------------------------------------------------------
interface seq_mult_ctrl_if;
    import seq_mult_ctrl_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/seq_mult_ctrl_adder.sv
// -----------------------------------------------------------------------------
// adder_32
// The shared 32-bit ripple adder. No carry-in, no carry-out; callers that
// need the carry recover it from the operand and sum MSBs.
//   a, b - addends
//   sum  - a + b modulo 2^32
// -----------------------------------------------------------------------------
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
// Unsigned 32x32 -> 64 shift-add multiplier. Sequences the shared adder
// through 32 conditional add/shift iterations under a start/busy/done
// handshake. With ZERO_SKIP set, a zero operand completes in one cycle.
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - request/response bundle (slave side)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start
// S_RUN  | one add/shift iteration per cycle, busy high
// S_DONE | result on product, done high for this cycle; start accepted
// -----------------------------------------------------------------------------
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_ctrl_if.slave  bus
);

    state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] shifted;
    logic               accept;
    logic               zero_op;
    logic               last_iter;

    // start is only honoured between operations.
    assign accept    = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign zero_op   = ZERO_SKIP && ((bus.a == '0) || (bus.b == '0));
    assign last_iter = (cnt == ITER_LAST);

    assign addend = lo[0] ? mcand : '0;

    adder_32 u_adder (
        .a   (hi),
        .b   (addend),
        .sum (sum)
    );

    // Carry out of hi + addend: both MSBs set, or exactly one set and the
    // sum MSB cleared by the ripple.
    assign carry = (hi[WIDTH-1] & addend[WIDTH-1])
                 | ((hi[WIDTH-1] ^ addend[WIDTH-1]) & ~sum[WIDTH-1]);

    // {carry, sum, lo} shifted right by one; lo[0] has been consumed.
    assign shifted = {carry, sum, lo[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = zero_op ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                if (accept) begin
                    state_nxt = zero_op ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand <= bus.a;
            lo    <= bus.b;
            hi    <= '0;
            cnt   <= '0;
            if (zero_op) begin
                product_q <= '0;
            end
        end else if (state == S_RUN) begin
            hi  <= shifted[2*WIDTH-1:WIDTH];
            lo  <= shifted[WIDTH-1:0];
            cnt <= cnt + 5'd1;
            if (last_iter) begin
                product_q <= shifted;
            end
        end
    end

    assign bus.product = product_q;

endmodule
